scanchain_wb_bridge: RTL and testbench
======================================

# scanchain_wb_bridge

Parametrised Wishbone-to-scan-chain bridge. It is the next-generation replacement for the fixed 70-bit local scan chain that sits between the SERV bus arbiter and the external scan host. It latches one CPU bus request and serialises it as a tagged frame. It returns the host's response as a single-cycle `o_wb_ack` only when the tag matches, and it times out abandoned requests. Everything runs on one clock; the scan host drives sampled strobes rather than a separate scan clock.

## Interface

Parameters:
- `ADR_WIDTH`, default 32: Wishbone address width.
- `DAT_WIDTH`, default 32: data width; must be a multiple of 8.
- `SEL_WIDTH`, default `DAT_WIDTH/8`: byte-select width.
- `TIMEOUT`, default 4096: cycles from latch to forced error-ack; 0 disables the timeout.
- Derived `OUT_LEN = ADR_WIDTH+DAT_WIDTH+SEL_WIDTH+3`, `IN_LEN = DAT_WIDTH+3`, `SCAN_LEN = max(OUT_LEN, IN_LEN)`; 71/35/71 at defaults.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_wb_adr`  in  `ADR_WIDTH`  request address.
- `i_wb_dat`  in  `DAT_WIDTH`  write data.
- `i_wb_sel`  in  `SEL_WIDTH`  byte selects.
- `i_wb_we`  in  1  write enable.
- `i_wb_cyc`  in  1  request valid; held until ack.
- `o_wb_rdt`  out  `DAT_WIDTH`  read data; valid while `o_wb_ack`=1.
- `o_wb_ack`  out  1  one-cycle acknowledge.
- `o_wb_err`  out  1  high together with `o_wb_ack` on timeout.
- `i_scan_shift`  in  1  shift both chains one bit.
- `i_scan_capture`  in  1  load the outgoing frame.
- `i_scan_update`  in  1  decode the incoming frame.
- `i_scan_data`  in  1  serial in.
- `o_scan_data`  out  1  serial out, `out_sr[0]`.
- `o_timer_irq`  out  1  timer interrupt from the host, registered.
- `o_busy`  out  1  state ≠ IDLE.

## Operation

State machine:
- IDLE: `i_wb_cyc`=1 latches adr, dat, sel and we into request registers, clears the timeout counter and moves to LATCHED.
- LATCHED: `i_scan_capture` moves to WAIT_RESP.
- WAIT_RESP: `i_scan_update` with resp.ack=1 and resp.tag=`tag` sets `o_wb_rdt`=resp.data, moves to ACK and toggles `tag`. A mismatched tag or ack=0 is ignored.
- ACK: `o_wb_ack`=1 for exactly this cycle, then IDLE. `i_wb_cyc` is not sampled in ACK.
- Timeout: in LATCHED or WAIT_RESP, when the counter reaches `TIMEOUT`-1, move to ACK with `o_wb_rdt`=0, `o_wb_err`=1 and toggle `tag`.
- A response update arriving in LATCHED is ignored, because the host has not yet seen the request.

Outgoing frame, LSB shifted first: bit0 cyc, bit1 tag, bit2 we, then sel, then dat, then adr at the MSBs. Bits above `OUT_LEN` are zero.
- cyc=1 in LATCHED and WAIT_RESP.
- In IDLE and ACK, capture loads an all-zero frame except the tag bit.

Chain behaviour:
- Shift: `out_sr <= {1'b0, out_sr[SCAN_LEN-1:1]}` and `in_sr <= {i_scan_data, in_sr[SCAN_LEN-1:1]}`.
- The host shifts exactly `SCAN_LEN` bits per transaction, incoming frame bit0 first.
- Incoming frame in `in_sr[IN_LEN-1:0]`: bit0 irq, bit1 tag, bit2 ack, `[IN_LEN-1:3]` data.
- Every update sets `o_timer_irq` to the irq bit, in any state.

Simultaneous strobes:
- capture with shift: capture wins, no shift that cycle.
- update with shift: update decodes the pre-shift `in_sr`; the shift still occurs.
- capture with update: both act.

## Timing

- Reset values:
  - Outputs: `o_wb_ack`, `o_wb_err`, `o_wb_rdt`, `o_timer_irq`, `o_busy` and `o_scan_data` all 0.
  - Internal: `tag`=0, counter=0, both shift registers 0, state IDLE.
- Reset mid-transaction drops the request with no ack.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Cycle timing:
  - `i_wb_cyc` sampled at edge N gives `o_busy`=1 after N.
  - An update at edge M gives `o_wb_ack`=1 during cycle M+1 only.
  - The earliest re-accept is the edge after ack deasserts.
- Timeout: ack rises exactly `TIMEOUT` cycles after the latch edge.
- Tag arithmetic is 1 bit and wraps.
- The counter is `$clog2(TIMEOUT+1)` bits and never wraps: it stops when it reaches `TIMEOUT`-1.

## Test plan

- **Read round-trip:** cyc with adr=0x0000_1004, we=0, sel=0xF; capture, 71 shifts, in-frame data=0xDEADBEEF, ack=1, tag=0, update -> out-frame bits[70:39]=0x0000_1004 and bit0=1; one ack pulse with rdt=0xDEADBEEF and err=0; tag becomes 1.
- **Write frame:** we=1, dat=0x12345678, sel=0x3 -> captured frame shows bit2=1, sel=0x3 and dat=0x12345678.
- **Stale tag:** response with tag=1 while tag=0 -> no ack, stays WAIT_RESP; a following correct-tag response -> ack.
- **Timeout:** `TIMEOUT`=16, no response -> ack with err=1 and rdt=0 exactly 16 cycles after latch; next request frame carries tag=1.
- **IRQ and collisions:** update with irq=1 in IDLE -> `o_timer_irq`=1 and no ack; capture+shift in the same cycle -> no shift.
- **Reset mid-WAIT_RESP:** reset pulse -> state IDLE, tag=0, no ack, all outputs 0.

Source files
------------

// File: rtl/scanchain_wb_bridge.sv
// Wishbone-to-scan-chain bridge: latches one bus request, serialises it as a tagged frame
// for the scan host, and acknowledges only on a tag-matching response or a timeout.
module scanchain_wb_bridge #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] i_wb_adr,
  input  logic [DAT_WIDTH-1:0] i_wb_dat,
  input  logic [SEL_WIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic                 i_wb_cyc,
  output logic [DAT_WIDTH-1:0] o_wb_rdt,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  input  logic                 i_scan_shift,
  input  logic                 i_scan_capture,
  input  logic                 i_scan_update,
  input  logic                 i_scan_data,
  output logic                 o_scan_data,
  output logic                 o_timer_irq,
  output logic                 o_busy
);

  localparam int OUT_LEN  = ADR_WIDTH + DAT_WIDTH + SEL_WIDTH + 3;
  localparam int IN_LEN   = DAT_WIDTH + 3;
  localparam int SCAN_LEN = (OUT_LEN > IN_LEN) ? OUT_LEN : IN_LEN;
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    LATCHED,
    WAIT_RESP,
    ACK
  } state_t;

  state_t               state;
  logic [ADR_WIDTH-1:0] req_adr;
  logic [DAT_WIDTH-1:0] req_dat;
  logic [SEL_WIDTH-1:0] req_sel;
  logic                 req_we;
  logic                 tag;
  logic [CNT_W-1:0]     cnt;
  logic [SCAN_LEN-1:0]  out_sr;
  logic [SCAN_LEN-1:0]  in_sr;

  logic [SCAN_LEN-1:0]  cap_frame;
  logic                 pending;
  logic                 in_irq;
  logic                 in_tag;
  logic                 in_ack;
  logic [DAT_WIDTH-1:0] in_data;
  logic                 resp_valid;
  logic                 timeout_hit;

  // Outside an active request the host only learns the current tag, so it can resync.
  always_comb begin
    pending   = (state == LATCHED) || (state == WAIT_RESP);
    cap_frame = '0;
    cap_frame[1] = tag;
    if (pending) begin
      cap_frame[OUT_LEN-1:0] = {req_adr, req_dat, req_sel, req_we, tag, 1'b1};
    end
  end

  assign in_irq      = in_sr[0];
  assign in_tag      = in_sr[1];
  assign in_ack      = in_sr[2];
  assign in_data     = in_sr[IN_LEN-1:3];
  assign resp_valid  = (state == WAIT_RESP) && i_scan_update && in_ack && (in_tag == tag);
  assign timeout_hit = (TIMEOUT != 0) && pending && (cnt == CNT_LAST);
  assign o_scan_data = out_sr[0];

  // Capture takes priority over shift on both chains; update always sees the pre-shift frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sr      <= '0;
      in_sr       <= '0;
      o_timer_irq <= 1'b0;
    end else begin
      if (i_scan_capture) begin
        out_sr <= cap_frame;
      end else if (i_scan_shift) begin
        out_sr <= {1'b0, out_sr[SCAN_LEN-1:1]};
      end
      if (i_scan_shift && !i_scan_capture) begin
        in_sr <= {i_scan_data, in_sr[SCAN_LEN-1:1]};
      end
      if (i_scan_update) begin
        o_timer_irq <= in_irq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_adr  <= '0;
      req_dat  <= '0;
      req_sel  <= '0;
      req_we   <= 1'b0;
      tag      <= 1'b0;
      cnt      <= '0;
      o_wb_rdt <= '0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc) begin
            req_adr <= i_wb_adr;
            req_dat <= i_wb_dat;
            req_sel <= i_wb_sel;
            req_we  <= i_wb_we;
            cnt     <= '0;
            o_busy  <= 1'b1;
            state   <= LATCHED;
          end
        end
        LATCHED, WAIT_RESP: begin
          // A genuine response beats a timeout landing on the same edge.
          if (resp_valid) begin
            o_wb_rdt <= in_data;
            o_wb_ack <= 1'b1;
            tag      <= ~tag;
            state    <= ACK;
          end else if (timeout_hit) begin
            o_wb_rdt <= '0;
            o_wb_ack <= 1'b1;
            o_wb_err <= 1'b1;
            tag      <= ~tag;
            state    <= ACK;
          end else begin
            if ((state == LATCHED) && i_scan_capture) begin
              state <= WAIT_RESP;
            end
            if (cnt != CNT_LAST) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ACK: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scanchain_wb_bridge.sv
// Self-checking bench for scanchain_wb_bridge: a queue-based transaction model checked every
// cycle, plus directed scenarios with hand-computed frame and response values.
module tb_scanchain_wb_bridge;

  localparam int ADR_WIDTH = 32;
  localparam int DAT_WIDTH = 32;
  localparam int SEL_WIDTH = 4;
  localparam int TIMEOUT   = 200;
  localparam int OUT_LEN   = ADR_WIDTH + DAT_WIDTH + SEL_WIDTH + 3;
  localparam int IN_LEN    = DAT_WIDTH + 3;
  localparam int SCAN_LEN  = (OUT_LEN > IN_LEN) ? OUT_LEN : IN_LEN;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ADR_WIDTH-1:0] i_wb_adr;
  logic [DAT_WIDTH-1:0] i_wb_dat;
  logic [SEL_WIDTH-1:0] i_wb_sel;
  logic                 i_wb_we;
  logic                 i_wb_cyc;
  logic [DAT_WIDTH-1:0] o_wb_rdt;
  logic                 o_wb_ack;
  logic                 o_wb_err;
  logic                 i_scan_shift;
  logic                 i_scan_capture;
  logic                 i_scan_update;
  logic                 i_scan_data;
  logic                 o_scan_data;
  logic                 o_timer_irq;
  logic                 o_busy;

  always #5 clk = ~clk;

  scanchain_wb_bridge #(
    .ADR_WIDTH(ADR_WIDTH),
    .DAT_WIDTH(DAT_WIDTH),
    .SEL_WIDTH(SEL_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_wb_adr      (i_wb_adr),
    .i_wb_dat      (i_wb_dat),
    .i_wb_sel      (i_wb_sel),
    .i_wb_we       (i_wb_we),
    .i_wb_cyc      (i_wb_cyc),
    .o_wb_rdt      (o_wb_rdt),
    .o_wb_ack      (o_wb_ack),
    .o_wb_err      (o_wb_err),
    .i_scan_shift  (i_scan_shift),
    .i_scan_capture(i_scan_capture),
    .i_scan_update (i_scan_update),
    .i_scan_data   (i_scan_data),
    .o_scan_data   (o_scan_data),
    .o_timer_irq   (o_timer_irq),
    .o_busy        (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: a request is outstanding from latch until the edge that ends its ack.
  bit                   started = 1'b0;
  bit                   m_req, m_seen, m_ack, m_err, m_tag, m_irq;
  logic [DAT_WIDTH-1:0] m_rdt;
  logic [ADR_WIDTH-1:0] m_adr;
  logic [DAT_WIDTH-1:0] m_dat;
  logic [SEL_WIDTH-1:0] m_sel;
  logic                 m_we;
  int                   m_age;
  bit                   out_q[$];
  bit                   in_q[$];

  always @(posedge clk) begin : model
    logic [SCAN_LEN-1:0]  fr;
    logic [DAT_WIDTH-1:0] rdata;
    bit                   r_irq, r_tag, r_ack;
    if (reset) begin
      started = 1'b1;
      m_req = 0; m_seen = 0; m_ack = 0; m_err = 0; m_tag = 0; m_irq = 0;
      m_rdt = '0; m_age = 0;
      out_q = {};
      in_q  = {};
      for (int i = 0; i < SCAN_LEN; i++) begin
        out_q.push_back(1'b0);
        in_q.push_back(1'b0);
      end
    end else if (started) begin
      r_irq = in_q[0];
      r_tag = in_q[1];
      r_ack = in_q[2];
      for (int i = 0; i < DAT_WIDTH; i++) rdata[i] = in_q[3 + i];
      if (i_scan_capture) begin
        fr = '0;
        if (m_req && !m_ack) fr[OUT_LEN-1:0] = {m_adr, m_dat, m_sel, m_we, m_tag, 1'b1};
        else fr[1] = m_tag;
        out_q = {};
        for (int i = 0; i < SCAN_LEN; i++) out_q.push_back(fr[i]);
      end else if (i_scan_shift) begin
        void'(out_q.pop_front());
        out_q.push_back(1'b0);
      end
      if (i_scan_shift && !i_scan_capture) begin
        void'(in_q.pop_front());
        in_q.push_back(i_scan_data);
      end
      if (i_scan_update) m_irq = r_irq;
      if (m_ack) begin
        m_ack = 0; m_err = 0; m_req = 0;
      end else if (!m_req) begin
        if (i_wb_cyc) begin
          m_req = 1; m_seen = 0; m_age = 0;
          m_adr = i_wb_adr; m_dat = i_wb_dat; m_sel = i_wb_sel; m_we = i_wb_we;
        end
      end else begin
        m_age++;
        if (i_scan_update && m_seen && r_ack && (r_tag == m_tag)) begin
          m_ack = 1; m_err = 0; m_rdt = rdata; m_tag = !m_tag;
        end else if ((TIMEOUT != 0) && (m_age == TIMEOUT)) begin
          m_ack = 1; m_err = 1; m_rdt = '0; m_tag = !m_tag;
        end else if (i_scan_capture) begin
          m_seen = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("ack", 64'(o_wb_ack), 64'(m_ack));
      checkOutput("err", 64'(o_wb_err), 64'(m_err));
      if (m_ack) checkOutput("rdt", 64'(o_wb_rdt), 64'(m_rdt));
      checkOutput("busy", 64'(o_busy), 64'(m_req));
      checkOutput("timer_irq", 64'(o_timer_irq), 64'(m_irq));
      checkOutput("scan_out", 64'(o_scan_data), 64'(out_q[0]));
    end
  end

  function automatic logic [IN_LEN-1:0] mkResp(input logic irq, input logic tag, input logic ack,
                                               input logic [DAT_WIDTH-1:0] data);
    return {data, ack, tag, irq};
  endfunction

  task automatic applyStimulus(input bit cap, input bit sh, input bit upd, input bit din);
    i_scan_capture = cap;
    i_scan_shift   = sh;
    i_scan_update  = upd;
    i_scan_data    = din;
    @(negedge clk);
    i_scan_capture = 1'b0;
    i_scan_shift   = 1'b0;
    i_scan_update  = 1'b0;
    i_scan_data    = 1'b0;
  endtask

  task automatic wbRequest(input logic [ADR_WIDTH-1:0] adr, input logic [DAT_WIDTH-1:0] dat,
                           input logic [SEL_WIDTH-1:0] sel, input logic we);
    i_wb_adr = adr;
    i_wb_dat = dat;
    i_wb_sel = sel;
    i_wb_we  = we;
    i_wb_cyc = 1'b1;
    @(negedge clk);
  endtask

  task automatic hostXfer(input logic [IN_LEN-1:0] resp, input bit upd, input bit upd_with_shift,
                          output logic [SCAN_LEN-1:0] seen);
    logic [SCAN_LEN-1:0] rf;
    rf = SCAN_LEN'(resp);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < SCAN_LEN; k++) begin
      seen[k] = o_scan_data;
      applyStimulus(1'b0, 1'b1, 1'b0, rf[k]);
    end
    if (upd) applyStimulus(1'b0, upd_with_shift, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [SCAN_LEN-1:0] seen;
    int n;
    reset = 1'b1;
    i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
    i_scan_shift = 1'b0; i_scan_capture = 1'b0; i_scan_update = 1'b0; i_scan_data = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", 64'(o_wb_ack), 64'd0);
    checkOutput("reset_rdt", 64'(o_wb_rdt), 64'd0);
    checkOutput("reset_busy", 64'(o_busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Read round-trip, tag 0 -> 1
    $display("[TB] read round-trip");
    wbRequest(32'h0000_1004, 32'h0, 4'hF, 1'b0);
    hostXfer(mkResp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF), 1'b1, 1'b0, seen);
    checkOutput("rd_frame_adr", 64'(seen[70:39]), 64'h0000_1004);
    checkOutput("rd_frame_cyc", 64'(seen[0]), 64'd1);
    checkOutput("rd_frame_tag", 64'(seen[1]), 64'd0);
    checkOutput("rd_frame_sel", 64'(seen[6:3]), 64'hF);
    checkOutput("rd_ack", 64'(o_wb_ack), 64'd1);
    checkOutput("rd_rdt", 64'(o_wb_rdt), 64'hDEAD_BEEF);
    checkOutput("rd_err", 64'(o_wb_err), 64'd0);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    checkOutput("rd_ack_single", 64'(o_wb_ack), 64'd0);

    // Write frame, tag 1 -> 0
    $display("[TB] write frame");
    wbRequest(32'h0000_2000, 32'h1234_5678, 4'h3, 1'b1);
    hostXfer(mkResp(1'b0, 1'b1, 1'b1, 32'h0), 1'b1, 1'b0, seen);
    checkOutput("wr_frame_we", 64'(seen[2]), 64'd1);
    checkOutput("wr_frame_tag", 64'(seen[1]), 64'd1);
    checkOutput("wr_frame_sel", 64'(seen[6:3]), 64'h3);
    checkOutput("wr_frame_dat", 64'(seen[38:7]), 64'h1234_5678);
    checkOutput("wr_ack", 64'(o_wb_ack), 64'd1);
    i_wb_cyc = 1'b0;
    @(negedge clk);

    // Timeout with no host activity, tag 0 -> 1
    $display("[TB] timeout");
    wbRequest(32'h0000_0ABC, 32'h0, 4'hF, 1'b0);
    n = 0;
    while (!o_wb_ack && n < 2 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_latency", 64'(n), 64'(TIMEOUT));
    checkOutput("to_err", 64'(o_wb_err), 64'd1);
    checkOutput("to_rdt", 64'(o_wb_rdt), 64'd0);
    i_wb_cyc = 1'b0;
    @(negedge clk);

    // Stale tag ignored, then the matching response completes, tag 1 -> 0
    $display("[TB] stale tag");
    wbRequest(32'h0000_3000, 32'h0, 4'hF, 1'b0);
    hostXfer(mkResp(1'b0, 1'b0, 1'b1, 32'h1111_1111), 1'b1, 1'b0, seen);
    checkOutput("to_next_tag", 64'(seen[1]), 64'd1);
    checkOutput("stale_no_ack", 64'(o_wb_ack), 64'd0);
    checkOutput("stale_busy", 64'(o_busy), 64'd1);
    hostXfer(mkResp(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D), 1'b1, 1'b0, seen);
    checkOutput("good_ack", 64'(o_wb_ack), 64'd1);
    checkOutput("good_rdt", 64'(o_wb_rdt), 64'hCAFE_F00D);
    i_wb_cyc = 1'b0;
    @(negedge clk);

    // Update in IDLE only moves the irq
    $display("[TB] irq in idle");
    hostXfer(mkResp(1'b1, 1'b0, 1'b1, 32'h0000_0055), 1'b1, 1'b0, seen);
    checkOutput("idle_frame_lo", 64'(seen[63:0]), 64'd0);
    checkOutput("idle_frame_hi", 64'(seen[70:64]), 64'd0);
    checkOutput("idle_irq", 64'(o_timer_irq), 64'd1);
    checkOutput("idle_no_ack", 64'(o_wb_ack), 64'd0);

    // Capture+shift collision, then update+shift collision, tag 0 -> 1
    $display("[TB] strobe collisions");
    wbRequest(32'h0000_4000, 32'h0, 4'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("cap_shift_bit0", 64'(o_scan_data), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("cap_shift_bit1", 64'(o_scan_data), 64'd0);
    hostXfer(mkResp(1'b1, 1'b0, 1'b1, 32'h600D_F00D), 1'b1, 1'b1, seen);
    checkOutput("upd_shift_ack", 64'(o_wb_ack), 64'd1);
    checkOutput("upd_shift_rdt", 64'(o_wb_rdt), 64'h600D_F00D);
    i_wb_cyc = 1'b0;
    @(negedge clk);

    // Reset in the middle of WAIT_RESP with tag 1
    $display("[TB] reset mid-transaction");
    wbRequest(32'h0000_5000, 32'h0, 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    i_wb_cyc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ack", 64'(o_wb_ack), 64'd0);
    checkOutput("rst_err", 64'(o_wb_err), 64'd0);
    checkOutput("rst_rdt", 64'(o_wb_rdt), 64'd0);
    checkOutput("rst_irq", 64'(o_timer_irq), 64'd0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_scan", 64'(o_scan_data), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_no_ack", 64'(o_wb_ack), 64'd0);
    wbRequest(32'h0000_6000, 32'h0, 4'hF, 1'b0);
    hostXfer(mkResp(1'b0, 1'b0, 1'b1, 32'h0000_0077), 1'b1, 1'b0, seen);
    checkOutput("rst_tag_frame", 64'(seen[1]), 64'd0);
    checkOutput("rst_after_ack", 64'(o_wb_ack), 64'd1);
    checkOutput("rst_after_rdt", 64'(o_wb_rdt), 64'h77);
    i_wb_cyc = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
